// File: rtl/decode_queue.sv
// decode_queue: instruction queue with pre-decode between fetch and decode.
//
// Buffers up to DEPTH fetched instructions so that decode stalls do not stall
// fetch. Every instruction is classified at enqueue time (format class,
// register indices, immediate), so decode reads stored fields instead of
// re-deriving them. A single-cycle flush discards the whole queue.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   CNT_W  width of the occupancy count
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready, in_exc, in_insn, in_pc
//                    enqueue side (push = in_valid & in_ready)
//   flush            discard all entries; a same-cycle push is dropped
//   out_valid/out_ready, out_exc, out_insn, out_pc, out_fmt, out_imm,
//   out_rs1, out_rs2, out_rd
//                    head of queue (pop = out_valid & out_ready);
//                    out_fmt is one-hot {r,i,s,b,u,j,invalid}
//   count            current occupancy
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_exc,
    input  logic [31:0]      in_insn,
    input  logic [29:0]      in_pc,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_exc,
    output logic [31:0]      out_insn,
    output logic [29:0]      out_pc,
    output logic [6:0]       out_fmt,
    output logic [31:0]      out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("decode_queue: DEPTH must be a power of two and at least 2");
    end

    // One-hot format encoding {r,i,s,b,u,j,invalid}
    localparam logic [6:0] FMT_R   = 7'b100_0000;
    localparam logic [6:0] FMT_I   = 7'b010_0000;
    localparam logic [6:0] FMT_S   = 7'b001_0000;
    localparam logic [6:0] FMT_B   = 7'b000_1000;
    localparam logic [6:0] FMT_U   = 7'b000_0100;
    localparam logic [6:0] FMT_J   = 7'b000_0010;
    localparam logic [6:0] FMT_INV = 7'b000_0001;

    // Major opcodes, insn[6:2] (insn[1:0] must be 2'b11)
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    // Control state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Entry payload (not reset; only meaningful while the entry is occupied)
    logic             ent_exc_q  [DEPTH];
    logic [31:0]      ent_insn_q [DEPTH];
    logic [29:0]      ent_pc_q   [DEPTH];
    logic [6:0]       ent_fmt_q  [DEPTH];
    logic [31:0]      ent_imm_q  [DEPTH];
    logic [4:0]       ent_rd_q   [DEPTH];

    logic             push;
    logic             pop;

    logic [6:0]       dec_fmt;
    logic [31:0]      dec_imm;
    logic [4:0]       dec_rd;

    // Pre-decode of the incoming instruction
    always_comb begin
        dec_fmt = FMT_INV;
        dec_imm = in_insn;          // illegal encodings pass the word through as tval
        dec_rd  = in_insn[11:7];
        if (in_insn[1:0] == 2'b11) begin
            unique case (in_insn[6:2])
                OPC_OP: begin
                    dec_fmt = FMT_R;
                    dec_imm = 32'd0;
                end
                OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                    dec_fmt = FMT_I;
                    dec_imm = {{20{in_insn[31]}}, in_insn[31:20]};
                end
                OPC_STORE: begin
                    dec_fmt = FMT_S;
                    dec_imm = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
                    dec_rd  = 5'd0;     // bits [11:7] hold immediate, not a destination
                end
                OPC_BRANCH: begin
                    dec_fmt = FMT_B;
                    dec_imm = {{19{in_insn[31]}}, in_insn[31], in_insn[7],
                               in_insn[30:25], in_insn[11:8], 1'b0};
                    dec_rd  = 5'd0;
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_fmt = FMT_U;
                    dec_imm = {in_insn[31:12], 12'd0};
                end
                OPC_JAL: begin
                    dec_fmt = FMT_J;
                    dec_imm = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12],
                               in_insn[20], in_insn[30:21], 1'b0};
                end
                default: begin
                    dec_fmt = FMT_INV;
                    dec_imm = in_insn;
                end
            endcase
        end
    end

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    // Next-state for pointers and occupancy; flush overrides everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_exc_q[wr_ptr_q]  <= in_exc;
            ent_insn_q[wr_ptr_q] <= in_insn;
            ent_pc_q[wr_ptr_q]   <= in_pc;
            ent_fmt_q[wr_ptr_q]  <= dec_fmt;
            ent_imm_q[wr_ptr_q]  <= dec_imm;
            ent_rd_q[wr_ptr_q]   <= dec_rd;
        end
    end

    // Head fields come straight from storage; no same-cycle bypass
    assign out_exc  = ent_exc_q[rd_ptr_q];
    assign out_insn = ent_insn_q[rd_ptr_q];
    assign out_pc   = ent_pc_q[rd_ptr_q];
    assign out_fmt  = ent_fmt_q[rd_ptr_q];
    assign out_imm  = ent_imm_q[rd_ptr_q];
    assign out_rd   = ent_rd_q[rd_ptr_q];
    assign out_rs1  = out_insn[19:15];
    assign out_rs2  = out_insn[24:20];
    assign count    = count_q;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_exc = 1'b0;
    logic [31:0]      in_insn = '0;
    logic [29:0]      in_pc = '0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_exc;
    logic [31:0]      out_insn;
    logic [29:0]      out_pc;
    logic [6:0]       out_fmt;
    logic [31:0]      out_imm;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int failures = 0;

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_exc(in_exc), .in_insn(in_insn), .in_pc(in_pc),
        .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_exc(out_exc),
        .out_insn(out_insn), .out_pc(out_pc), .out_fmt(out_fmt), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of what fetch handed over
    typedef struct {
        logic [31:0] insn;
        logic [29:0] pc;
        logic        exc;
    } ent_t;
    ent_t model[$];

    // Values of the current cycle's inputs, remembered for the model update
    bit cur_v, cur_ordy, cur_fl, cur_exc;
    logic [31:0] cur_insn;
    logic [29:0] cur_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decoding rules written as class lookup plus shift/or arithmetic
    function automatic void ref_dec(input logic [31:0] w, output logic [6:0] fmt,
                                    output logic [31:0] imm, output logic [4:0] rd,
                                    output bit imm_defined);
        logic [31:0] sx;
        sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
        fmt = 7'b000_0001;
        imm = w;
        rd = w[11:7];
        imm_defined = 1;
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h33: begin fmt = 7'b100_0000; imm_defined = 0; end
                7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
                    fmt = 7'b010_0000;
                    imm = (sx << 12) | (w >> 20);
                end
                7'h23: begin
                    fmt = 7'b001_0000;
                    imm = (sx << 12) | ((w >> 20) & 32'hFE0) | ((w >> 7) & 32'h1F);
                    rd = 0;
                end
                7'h63: begin
                    fmt = 7'b000_1000;
                    imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
                        | (32'(w[11:8]) << 1);
                    rd = 0;
                end
                7'h37, 7'h17: begin
                    fmt = 7'b000_0100;
                    imm = w & 32'hFFFF_F000;
                end
                7'h6F: begin
                    fmt = 7'b000_0010;
                    imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
                        | (32'(w[30:21]) << 1);
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check_model();
        logic [6:0] f;
        logic [31:0] im;
        logic [4:0] r;
        bit imd;
        chk("count", 32'(count), 32'(model.size()));
        chk("in_ready", 32'(in_ready), 32'(model.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(model.size() != 0));
        if (model.size() != 0) begin
            ref_dec(model[0].insn, f, im, r, imd);
            chk("head_pc", 32'(out_pc), 32'(model[0].pc));
            chk("head_insn", out_insn, model[0].insn);
            chk("head_exc", 32'(out_exc), 32'(model[0].exc));
            chk("head_fmt", 32'(out_fmt), 32'(f));
            if (imd) chk("head_imm", out_imm, im);
            chk("head_rd", 32'(out_rd), 32'(r));
            chk("head_rs1", 32'(out_rs1), 32'(model[0].insn[19:15]));
            chk("head_rs2", 32'(out_rs2), 32'(model[0].insn[24:20]));
        end
    endtask

    // Apply inputs mid-cycle and check the settled outputs
    task automatic drive(input bit v, input logic [31:0] insn, input logic [29:0] pc,
                         input bit exc, input bit ordy, input bit fl);
        @(negedge clk);
        in_valid = v; in_insn = insn; in_pc = pc; in_exc = exc;
        out_ready = ordy; flush = fl;
        cur_v = v; cur_insn = insn; cur_pc = pc; cur_exc = exc;
        cur_ordy = ordy; cur_fl = fl;
        #1;
        check_model();
    endtask

    // Clock edge: advance the model by the same handshake rules
    task automatic tick();
        bit can_push;
        bit do_pop;
        can_push = cur_v && (model.size() < DEPTH);
        do_pop = cur_ordy && (model.size() != 0);
        @(posedge clk);
        if (cur_fl) begin
            model.delete();
        end else begin
            if (do_pop) void'(model.pop_front());
            if (can_push) model.push_back('{insn: cur_insn, pc: cur_pc, exc: cur_exc});
        end
    endtask

    task automatic step(input bit v, input logic [31:0] insn, input logic [29:0] pc,
                        input bit exc, input bit ordy, input bit fl);
        drive(v, insn, pc, exc, ordy, fl);
        tick();
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0] ops[13] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23,
                                7'h63, 7'h37, 7'h17, 7'h6F, 7'h00, 7'h7F};
        logic [31:0] w;
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 12)];
        return w;
    endfunction

    initial begin
        logic [29:0] pcn;

        // Reset state while reset is held
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        reset = 1'b0;

        // Fill to full with consumer stalled; fifth offer is refused
        for (int i = 0; i < 4; i++) step(1, rand_insn(), 30'((32'h100 + 4 * i) >> 2), 0, 0, 0);
        drive(1, 32'h0000_0013, 30'(32'h110 >> 2), 0, 0, 0);
        chk("full_in_ready", 32'(in_ready), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            chk("order_pc", 32'(out_pc), 32'((32'h100 + 4 * i) >> 2));
            tick();
        end
        step(0, 0, 0, 0, 0, 0);

        // Steady push+pop at occupancy 2 across several pointer wraps
        pcn = 30'h200;
        for (int i = 0; i < 2; i++) begin step(1, rand_insn(), pcn, 0, 0, 0); pcn++; end
        for (int i = 0; i < 10; i++) begin
            drive(1, rand_insn(), pcn, 0, 1, 0);
            chk("steady_count", 32'(count), 2);
            tick();
            pcn++;
        end
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 0);

        // Decode of known encodings
        step(1, 32'hFFF0_0093, 30'h300, 0, 0, 0);
        step(1, 32'hFE00_0EE3, 30'h301, 0, 0, 0);
        step(1, 32'h0000_0000, 30'h302, 0, 0, 0);
        step(1, 32'h0000_0013, 30'h303, 1, 0, 0);
        drive(1, 32'h0000_0013, 30'h304, 0, 1, 0);
        chk("addi_fmt", 32'(out_fmt), 32'h20);
        chk("addi_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(out_rd), 1);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        chk("beq_fmt", 32'(out_fmt), 32'h08);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_rd", 32'(out_rd), 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        chk("zero_fmt", 32'(out_fmt), 32'h01);
        chk("zero_imm", out_imm, 32'h0);
        chk("zero_exc", 32'(out_exc), 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        chk("exc_set", 32'(out_exc), 1);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        chk("exc_next_clear", 32'(out_exc), 0);
        tick();
        step(0, 0, 0, 0, 0, 0);

        // Flush together with a push: the flush-cycle instruction is dropped
        for (int i = 0; i < 3; i++) step(1, rand_insn(), 30'h400 + 30'(i), 0, 0, 0);
        drive(1, 32'h0000_0033, 30'h4FF, 0, 1, 1);
        chk("flush_in_ready", 32'(in_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("post_flush_count", 32'(count), 0);
        chk("post_flush_valid", 32'(out_valid), 0);
        tick();
        step(1, 32'h0000_0037, 30'h500, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Asynchronous reset between edges, mid-stream
        step(1, rand_insn(), 30'h600, 0, 0, 0);
        step(1, rand_insn(), 30'h601, 0, 0, 0);
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_in_ready", 32'(in_ready), 1);
        chk("async_rst_out_valid", 32'(out_valid), 0);
        model.delete();
        @(negedge clk);
        reset = 1'b0;
        step(1, 32'h0010_0093, 30'h700, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        chk("after_rst_pc", 32'(out_pc), 32'h700);
        chk("after_rst_imm", out_imm, 32'h1);
        tick();

        // Randomized traffic against the model
        pcn = 30'h1000;
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, rand_insn(), pcn, ($urandom % 8) == 0,
                 ($urandom % 3) != 0, ($urandom % 30) == 0);
            pcn++;
        end
        step(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised instruction queue with pre-decode, placed between the fetch stage and the decode/issue logic.
- Decouples fetch from decode stalls by buffering up to DEPTH fetched instructions.
- Each instruction is pre-decoded at enqueue (format class, register indices, sign-extended immediate), so decode reads stored fields rather than re-deriving them.
- Supports a single-cycle flush on branch mispredict or PC redirect.

Parameters:
DEPTH, 4, number of queue entries; must be a power of two and at least 2 (elaboration-time check).
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
in_valid  input  1  fetch presents an instruction
in_exc  input  1  fetch fault attached to this instruction
in_insn  input  32  raw instruction word
in_pc  input  30  instruction PC[31:2]
in_ready  output  1  queue can accept; high when count < DEPTH
flush  input  1  discard all entries (branch miss / redirect)
out_valid  output  1  head entry is valid
out_ready  input  1  consumer takes head this cycle
out_exc  output  1  head carries a fetch fault
out_insn  output  32  head raw instruction
out_pc  output  30  head PC[31:2]
out_fmt  output  7  one-hot {r,i,s,b,u,j,invalid}
out_imm  output  32  head decoded immediate
out_rs1  output  5  head insn[19:15]
out_rs2  output  5  head insn[24:20]
out_rd  output  5  head rd; 0 for BRANCH/STORE
count  output  CNT_W  current occupancy

Behaviour:
Handshakes
- Push occurs when in_valid & in_ready.
- Pop occurs when out_valid & out_ready.
- out_valid = (count != 0). The head fields drive combinationally from storage.
- Latency: an instruction pushed in cycle N is visible at the head in cycle N+1 at the earliest. There is no same-cycle bypass.

Occupancy
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- At full (count == DEPTH), in_ready is 0. A pop in that cycle frees a slot, visible from the next cycle.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count disambiguates full from empty.

Pre-decode at push (from in_insn)
- in_insn[1:0] != 2'b11 or an unknown opcode gives fmt.invalid.
- Opcode classes:
  - OP → r.
  - OP_IMM, LOAD, JALR, MISC_MEM, SYSTEM → i.
  - STORE → s.
  - BRANCH → b.
  - LUI, AUIPC → u.
  - JAL → j.
- Immediate rules:
  - i: sign-extended insn[31:20].
  - s: sign-extended {insn[31:25], insn[11:7]}.
  - b: sign-extended {insn[31], insn[7], insn[30:25], insn[11:8], 0}.
  - u: {insn[31:12], 12'b0}.
  - j: sign-extended {insn[31], insn[19:12], insn[20], insn[30:21], 0}.
  - invalid: imm = insn (passed through for illegal-instruction tval).
- in_exc = 1: the entry stores exc = 1 with fields decoded as normal. The consumer treats fault as highest priority.

Flush
- When flush is high, the next state is count = 0 and both pointers = 0.
- A push in the flush cycle is dropped, even if in_ready was high.
- A pop in the flush cycle is still considered consumed by the consumer; the queue ignores it.
- in_ready in the flush cycle still reflects the pre-flush count.

Reset
- Asynchronous, immediate: count = 0, pointers = 0, out_valid = 0, in_ready = 1.
- Entry payload storage is not reset. Head fields are don't-care while out_valid = 0.
- A reset asserted mid-stream discards all entries. The first push after deassertion lands in entry 0.

Test Plan:
- Push 4 insns (DEPTH=4) with out_ready=0 → count 1,2,3,4; in_ready=0 after the fourth push; a fifth in_valid is not accepted. Then out_ready=1 → pops in order of PC 0x100,0x104,0x108,0x10C.
- Continuous push+pop at count=2 for 10 cycles → count stays 2; PCs emerge in order across pointer wrap (≥2 full wraps).
- Push I-type 0xFFF00093 (addi x1,x0,-1) → out_fmt=i, out_imm=0xFFFFFFFF, out_rd=1. Push B-type 0xFE000EE3 (beq x0,x0,-4) → out_fmt=b, out_imm=0xFFFFFFFC, out_rd=0.
- Push 0x00000000 → fmt.invalid, out_imm=0. Push with in_exc=1 → out_exc=1 on that entry only.
- Fill 3 entries, assert flush together with in_valid → next cycle count=0, out_valid=0; the flush-cycle instruction never appears.
- Fill 2 entries, pulse reset asynchronously between edges → count=0 and in_ready=1 immediately; next push appears at head with correct fields.
